alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter_pkg.sv | 28 ++
 rtl/alu_share_arbiter_alu_core.sv | 107 ++++++++++
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the two-requester shared-ALU arbiter:
//   default datapath width, 3-bit ALU op encoding and FSM state type.
package alu_share_arbiter_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Widen a single compare bit to a full-width 0/1 result.
  function automatic logic [DATA_W_DEF-1:0] flag_to_word(input logic flag);
    return {{(DATA_W_DEF-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// alu_core and its bitwise gate-level units
//   alu_core: purely combinational ALU shared by both requesters.
//   Ports:
//     op     [2:0]         operation select (see package encoding)
//     a, b   [DATA_W-1:0]  operands
//     result [DATA_W-1:0]  ALU result (ADD/SUB wrap, SLT/SLTU give 0 or 1)
//     zero                 result == 0
//   bw_and/bw_or/bw_xor/bw_nor: per-bit primitive gate arrays.

module bw_and #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    and u_gate (y[i], a[i], b[i]);
  end
endmodule

module bw_or #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    or u_gate (y[i], a[i], b[i]);
  end
endmodule

module bw_xor #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    xor u_gate (y[i], a[i], b[i]);
  end
endmodule

module bw_nor #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    nor u_gate (y[i], a[i], b[i]);
  end
endmodule

module alu_core
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [DATA_W-1:0] w_and;
  logic [DATA_W-1:0] w_or;
  logic [DATA_W-1:0] w_xor;
  logic [DATA_W-1:0] w_nor;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_lt_s;
  logic              w_lt_u;

  bw_and #(.W(DATA_W)) u_and (.a(a), .b(b), .y(w_and));
  bw_or  #(.W(DATA_W)) u_or  (.a(a), .b(b), .y(w_or));
  bw_xor #(.W(DATA_W)) u_xor (.a(a), .b(b), .y(w_xor));
  bw_nor #(.W(DATA_W)) u_nor (.a(a), .b(b), .y(w_nor));

  // Sum/difference truncate to DATA_W, giving modulo-2^DATA_W wrap.
  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt_s = $signed(a) < $signed(b);
  assign w_lt_u = a < b;

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = w_and;
      OP_OR:   result = w_or;
      OP_XOR:  result = w_xor;
      OP_NOR:  result = w_nor;
      OP_ADD:  result = w_sum;
      OP_SUB:  result = w_diff;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, w_lt_s};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, w_lt_u};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Two requesters share one combinational ALU. A round-robin grant is
//   issued in IDLE, the winner's operands are latched, evaluated in EXEC,
//   and the result is held in RESP until the consumer takes it.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     reqN_valid/ready           request handshake (N = 0, 1)
//     reqN_op [2:0]              ALU operation
//     reqN_a, reqN_b             operands, DATA_W bits
//     resp_valid/ready           response handshake
//     resp_id                    owning requester of the response
//     resp_result, resp_zero     ALU result and its zero flag
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | free; grants one valid requester and latches its operands
//   EXEC    | ALU evaluates latched operands; response registers load
//   RESP    | resp_valid high, response held until resp_ready
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero
);

  state_t            r_state;
  logic              r_last_grant;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_result;
  logic              r_resp_zero;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;

  // The grant must appear in the same cycle as valid, so ready is decoded
  // from the registered state. Reset masks it so nothing is accepted on a
  // reset cycle.
  assign w_idle = (r_state == ST_IDLE) && !reset;

  // Contention goes to the requester that did not win last time; a sole
  // requester wins whatever last_grant says.
  assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_op          <= OP_AND;
      r_a           <= '0;
      r_b           <= '0;
      r_id          <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op         <= w_gnt1 ? req1_op : req0_op;
            r_a          <= w_gnt1 ? req1_a  : req0_a;
            r_b          <= w_gnt1 ? req1_b  : req0_b;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_resp_result <= w_alu_result;
          r_resp_zero   <= w_alu_zero;
          r_resp_id     <= r_id;
          r_resp_valid  <= 1'b1;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          // Response registers are left untouched here so they stay stable
          // for the whole time resp_ready is low.
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs read as zero for the whole reset cycle, not only after the edge.
  assign resp_valid  = r_resp_valid && !reset;
  assign resp_id     = r_resp_id && !reset;
  assign resp_result = reset ? '0 : r_resp_result;
  assign resp_zero   = r_resp_zero && !reset;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_zero;
  logic [31:0] resp_result;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ALU written from the op definitions.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic lt;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: begin
        // Different signs: the negative one is smaller; same sign: magnitude order.
        if (a[31] != b[31]) lt = a[31];
        else lt = (a < b);
        return {31'd0, lt};
      end
      default: begin
        lt = (a < b);
        return {31'd0, lt};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req0_valid = 1; req1_valid = 1; resp_ready = 1;
    req0_op = 3'd4; req0_a = 32'h1234; req0_b = 32'h1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
      end
      checks++;
      if ({resp_valid, resp_id, resp_zero, resp_result} !== 35'd0) begin
        errors++; $display("FAIL reset_resp got v%b id%b z%b r%h exp all zero", resp_valid, resp_id, resp_zero, resp_result);
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_xor();
    do_reset();
    req0_valid = 1; req0_op = 3'd2; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    resp_ready = 1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL xor_grant got r0%b r1%b v%b exp 1 0 0", req0_ready, req1_ready, resp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({req0_ready, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL xor_exec got r0%b v%b exp 0 0", req0_ready, resp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_id, resp_zero, resp_result} !== {1'b1, 1'b0, 1'b0, 32'hF0F00F0F}) begin
      errors++; $display("FAIL xor_resp got v%b id%b z%b r%h exp v1 id0 z0 rf0f00f0f", resp_valid, resp_id, resp_zero, resp_result);
    end
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL xor_resp_ready got %b exp 0", req0_ready);
    end
    tick();
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if ({resp_valid, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL xor_done got v%b r0%b exp 0 0", resp_valid, req0_ready);
    end
  endtask

  task automatic test_contention();
    int exp_id;
    logic exp_g;
    logic [31:0] exp_r;
    do_reset();
    req0_valid = 1; req0_op = 3'd4; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1; req1_op = 3'd2; req1_a = 32'hAAAA5555; req1_b = 32'hAAAA5555;
    resp_ready = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_g = (k % 3 == 0);
      exp_id = (k / 3) % 2;
      checks++;
      if ({req0_ready, req1_ready} !== {exp_g && exp_id == 0, exp_g && exp_id == 1}) begin
        errors++; $display("FAIL cont_grant k%0d got %b%b exp id %0d grant %b", k, req0_ready, req1_ready, exp_id, exp_g);
      end
      checks++;
      if (resp_valid !== (k % 3 == 2)) begin
        errors++; $display("FAIL cont_valid k%0d got %b exp %b", k, resp_valid, (k % 3 == 2));
      end
      if (k % 3 == 2) begin
        exp_r = (exp_id == 0) ? 32'd30 : 32'd0;
        checks++;
        if ({resp_id, resp_zero, resp_result} !== {exp_id[0], (exp_r == 0), exp_r}) begin
          errors++; $display("FAIL cont_resp k%0d got id%b z%b r%h exp id%0d r%h", k, resp_id, resp_zero, resp_result, exp_id, exp_r);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_op = 3'd4; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
    resp_ready = 0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_grant got %b exp 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_op = 3'd1; req1_a = 32'h00F0; req1_b = 32'h0F00;
    @(negedge clk);
    checks++;
    if ({req1_ready, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_exec got r1%b v%b exp 0 0", req1_ready, resp_valid);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_id, resp_zero, resp_result, req1_ready} !== {1'b1, 1'b0, 1'b1, 32'd0, 1'b0}) begin
        errors++; $display("FAIL bp_hold k%0d got v%b id%b z%b r%h r1%b exp v1 id0 z1 r0 r1 0", k, resp_valid, resp_id, resp_zero, resp_result, req1_ready);
      end
      tick();
    end
    resp_ready = 1;
    @(negedge clk);
    checks++;
    if ({resp_valid, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release got v%b r1%b exp 1 0", resp_valid, req1_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_next_grant got v%b r1%b exp 0 1", resp_valid, req1_ready);
    end
    tick();
    req1_valid = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, 32'h0FF0}) begin
      errors++; $display("FAIL bp_or_resp got v%b id%b r%h exp v1 id1 r00000ff0", resp_valid, resp_id, resp_result);
    end
    tick();
  endtask

  task automatic test_slt();
    do_reset();
    req1_valid = 1; req1_op = 3'd6; req1_a = 32'h80000000; req1_b = 32'd1;
    resp_ready = 1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL slt_grant got %b%b exp 01", req0_ready, req1_ready);
    end
    tick();
    req1_op = 3'd7;
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_id, resp_zero, resp_result} !== {1'b1, 1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL slt_resp got v%b id%b z%b r%h exp v1 id1 z0 r1", resp_valid, resp_id, resp_zero, resp_result);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL sltu_grant got %b exp 1", req1_ready);
    end
    tick();
    req1_valid = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_id, resp_zero, resp_result} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL sltu_resp got v%b id%b z%b r%h exp v1 id1 z1 r0", resp_valid, resp_id, resp_zero, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    req0_valid = 1; req0_op = 3'd0; req0_a = 32'hFFFF; req0_b = 32'hFFFF;
    resp_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rexec_grant got %b exp 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    reset = 1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_result} !== 37'd0) begin
      errors++; $display("FAIL rexec_outputs got r%b%b v%b id%b z%b r%h exp all zero", req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_result);
    end
    tick();
    reset = 0;
    req0_valid = 1; req0_op = 3'd1; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = 3'd4; req1_a = 32'd7; req1_b = 32'd7;
    @(negedge clk);
    checks++;
    if ({resp_valid, req0_ready, req1_ready} !== 3'b010) begin
      errors++; $display("FAIL rexec_after got v%b r0%b r1%b exp 0 1 0", resp_valid, req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rexec_no_resp got %b exp 0", resp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL rexec_new_resp got v%b id%b r%h exp v1 id0 r3", resp_valid, resp_id, resp_result);
    end
    tick();
  endtask

  task automatic test_sole_requester();
    logic [31:0] sa [3];
    logic [31:0] sb [3];
    logic [31:0] se [3];
    sa[0] = 32'd0;   sb[0] = 32'd1; se[0] = 32'hFFFFFFFF;
    sa[1] = 32'd5;   sb[1] = 32'd5; se[1] = 32'd0;
    sa[2] = 32'd100; sb[2] = 32'd7; se[2] = 32'd93;
    do_reset();
    resp_ready = 1;
    for (int t = 0; t < 3; t++) begin
      req1_valid = 1; req1_op = 3'd5; req1_a = sa[t]; req1_b = sb[t];
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        errors++; $display("FAIL sole_grant t%0d got %b%b exp 01", t, req0_ready, req1_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b0) begin
        errors++; $display("FAIL sole_busy t%0d got %b exp 0", t, req1_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_id, resp_zero, resp_result} !== {1'b1, 1'b1, (se[t] == 0), se[t]}) begin
        errors++; $display("FAIL sole_resp t%0d got v%b id%b z%b r%h exp r%h", t, resp_valid, resp_id, resp_zero, resp_result, se[t]);
      end
      tick();
    end
    clear_inputs();
  endtask

  // Transaction-level model: tracks whether the block is free, how many
  // cycles have passed since the last accepted request, and what that
  // request must produce.
  task automatic test_random();
    bit          m_free = 1;
    int          m_age = 0;
    bit          m_last = 1;
    bit          m_id = 0;
    logic [31:0] m_res = 0;
    bit          win;
    bit          granted;
    bit          exp_rv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      req0_b = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
      req1_a = $urandom;
      req1_b = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
      resp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      granted = m_free && (req0_valid || req1_valid);
      win = 0;
      if (granted) win = (req0_valid && req1_valid) ? !m_last : req1_valid;
      checks++;
      if ({req0_ready, req1_ready} !== {granted && !win, granted && win}) begin
        errors++; $display("FAIL rand_grant c%0d got %b%b exp %b%b", c, req0_ready, req1_ready, granted && !win, granted && win);
      end
      exp_rv = !m_free && (m_age >= 2);
      checks++;
      if (resp_valid !== exp_rv) begin
        errors++; $display("FAIL rand_valid c%0d got %b exp %b", c, resp_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if ({resp_id, resp_zero, resp_result} !== {m_id, (m_res == 0), m_res}) begin
          errors++; $display("FAIL rand_resp c%0d got id%b z%b r%h exp id%b r%h", c, resp_id, resp_zero, resp_result, m_id, m_res);
        end
      end
      if (granted) begin
        m_free = 0;
        m_age = 1;
        m_id = win;
        m_last = win;
        m_res = win ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
      end else if (!m_free) begin
        if (m_age >= 2 && resp_ready) m_free = 1;
        else m_age = m_age + 1;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick();
    test_reset();
    test_xor();
    test_contention();
    test_backpressure();
    test_slt();
    test_reset_in_exec();
    test_sole_requester();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
